hazard_unit: RTL and testbench

Pipeline hazard and stall/flush generator for the 5-stage MIPS core. It produces the per-stage stall, flush and forwarding controls that the pipeline control registers and datapath muxes consume. It holds the only sequential state for multi-cycle hazards: a divider-occupancy FSM with a cycle counter. It also arbitrates data-memory wait, exceptions, load-use and branch-operand hazards.

---
 rtl/hazard_unit.sv | 102 ++++++++++
 tb/tb_hazard_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward generator and divider-occupancy FSM for the 5-stage MIPS pipeline
//   in : clk, rst (async, active-high), RsD/RtD, RsE/RtE, WriteRegE/M/W, RegWriteE/M/W,
//        MemReadE/M, BranchD, JumpSrcD, DivStartE, DmemStallM, ExceptM
//   out: StallF/D/E/M, FlushD/E/M/W, ForwardAE/BE (00 rf, 01 W, 10 M), ForwardAD/BD,
//        DivBusyE, DivReadyE
module hazard_unit #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemReadE,
  input  logic       MemReadM,
  input  logic [1:0] BranchD,
  input  logic       JumpSrcD,
  input  logic       DivStartE,
  input  logic       DmemStallM,
  input  logic       ExceptM,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       DivBusyE,
  output logic       DivReadyE
);
  localparam int CW = $clog2(DIV_CYCLES);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_t;
  divState_t state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic eLive, mLive, wLive, exAct, divHold, loadUse, brHaz;
  assign eLive = RegWriteE && WriteRegE != 5'd0;
  assign mLive = RegWriteM && WriteRegM != 5'd0;
  assign wLive = RegWriteW && WriteRegW != 5'd0;
  assign ForwardAE = (mLive && WriteRegM == RsE) ? 2'b10 : (wLive && WriteRegW == RsE) ? 2'b01 : 2'b00;
  assign ForwardBE = (mLive && WriteRegM == RtE) ? 2'b10 : (wLive && WriteRegW == RtE) ? 2'b01 : 2'b00;
  assign ForwardAD = mLive && WriteRegM == RsD;
  assign ForwardBD = mLive && WriteRegM == RtD;
  assign loadUse = MemReadE && WriteRegE != 5'd0 && (WriteRegE == RsD || WriteRegE == RtD);
  // A load in M cannot be forwarded to the D-stage comparator, so it stalls like an E producer.
  assign brHaz = (BranchD != 2'b00 || JumpSrcD) &&
                 ((eLive && (WriteRegE == RsD || WriteRegE == RtD)) ||
                  (MemReadM && WriteRegM != 5'd0 && (WriteRegM == RsD || WriteRegM == RtD)));
  // An exception only takes effect once the memory stall has cleared.
  assign exAct = ExceptM && !DmemStallM;
  assign divHold = state == BUSY || (state == IDLE && DivStartE);
  assign DivBusyE = state == BUSY;
  assign DivReadyE = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
    end
  end
  // The count runs through memory stalls; only DONE is held by them.
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    if (exAct) stateNext = IDLE;
    else if (state == IDLE && DivStartE) begin
      stateNext = BUSY;
      cntNext = CW'(DIV_CYCLES - 1);
    end else if (state == BUSY) begin
      if (cnt == '0) stateNext = DONE;
      else cntNext = cnt - 1'b1;
    end else if (state == DONE && !DmemStallM) stateNext = IDLE;
  end
  always_comb begin
    {StallF, StallD, StallE, StallM} = 4'b0000;
    {FlushD, FlushE, FlushM, FlushW} = 4'b0000;
    if (exAct) {FlushD, FlushE, FlushM, FlushW} = 4'b1111;
    else if (DmemStallM) begin
      {StallF, StallD, StallE, StallM} = 4'b1111;
      FlushW = 1'b1;
    end else if (divHold) begin
      {StallF, StallD, StallE} = 3'b111;
      FlushM = 1'b1;
    end else if (loadUse || brHaz) begin
      {StallF, StallD} = 2'b11;
      FlushE = 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized self-checking bench for hazard_unit
module tb_hazard_unit;
  localparam int DIV = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM, JumpSrcD, DivStartE, DmemStallM, ExceptM;
  logic [1:0] BranchD;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, ForwardAD, ForwardBD, DivBusyE, DivReadyE;
  logic [1:0] ForwardAE, ForwardBE;
  int nCompared = 0, nMismatched = 0;
  int cyc, bStart, bEnd;
  bit done;
  hazard_unit #(.DIV_CYCLES(DIV)) dut (
    .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .MemReadM(MemReadM), .BranchD(BranchD), .JumpSrcD(JumpSrcD),
    .DivStartE(DivStartE), .DmemStallM(DmemStallM), .ExceptM(ExceptM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .DivBusyE(DivBusyE), .DivReadyE(DivReadyE)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic clearIns();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM, JumpSrcD, DivStartE, DmemStallM, ExceptM} = '0;
    BranchD = 2'b00;
  endtask
  function automatic logic [1:0] fwdE(input logic [4:0] src);
    if (RegWriteM && WriteRegM != 0 && WriteRegM == src) return 2'b10;
    if (RegWriteW && WriteRegW != 0 && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic uses(input logic [4:0] r);
    return r != 0 && (r == RsD || r == RtD);
  endfunction
  task automatic randomCycle();
    logic busy, idle, exAct, divR, hz;
    logic [3:0] expS, expF;
    @(negedge clk);
    RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
    RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
    WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
    WriteRegW = 5'($urandom_range(0, 3));
    RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
    MemReadE = 1'($urandom); MemReadM = 1'($urandom); JumpSrcD = ($urandom_range(0, 3) == 0);
    BranchD = 2'($urandom); DivStartE = ($urandom_range(0, 7) == 0);
    DmemStallM = ($urandom_range(0, 4) == 0); ExceptM = ($urandom_range(0, 15) == 0);
    #2;
    busy = cyc >= bStart && cyc <= bEnd;
    idle = !busy && !done;
    exAct = ExceptM && !DmemStallM;
    divR = busy || (idle && DivStartE);
    hz = (MemReadE && uses(WriteRegE)) ||
         ((BranchD != 0 || JumpSrcD) && ((RegWriteE && uses(WriteRegE)) || (MemReadM && uses(WriteRegM))));
    expS = exAct ? 4'b0000 : DmemStallM ? 4'b1111 : divR ? 4'b1110 : hz ? 4'b1100 : 4'b0000;
    expF = exAct ? 4'b1111 : DmemStallM ? 4'b0001 : divR ? 4'b0010 : hz ? 4'b0100 : 4'b0000;
    check("rnd_stall", {StallF, StallD, StallE, StallM}, expS);
    check("rnd_flush", {FlushD, FlushE, FlushM, FlushW}, expF);
    check("rnd_fwdE", {ForwardAE, ForwardBE}, {fwdE(RsE), fwdE(RtE)});
    check("rnd_fwdD", {ForwardAD, ForwardBD},
          {RegWriteM && WriteRegM != 0 && WriteRegM == RsD, RegWriteM && WriteRegM != 0 && WriteRegM == RtD});
    check("rnd_div", {DivBusyE, DivReadyE}, {busy, done});
    if (exAct) begin bStart = 1; bEnd = 0; done = 0; end
    else if (idle && DivStartE) begin bStart = cyc + 1; bEnd = cyc + DIV; end
    else if (busy && cyc == bEnd) done = 1;
    else if (done && !DmemStallM) done = 0;
    cyc++;
  endtask
  initial begin
    clearIns();
    #2;
    check("reset_outs", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
                         ForwardAE, ForwardBE, ForwardAD, ForwardBD, DivBusyE, DivReadyE}, '0);
    @(negedge clk); rst = 1'b0;
    RegWriteM = 1; RegWriteW = 1; WriteRegM = 5; WriteRegW = 5; RsE = 5; #1;
    check("fwd_M", ForwardAE, 2'b10);
    RegWriteM = 0; #1;
    check("fwd_W", ForwardAE, 2'b01);
    RsE = 0; WriteRegW = 0; #1;
    check("fwd_r0", ForwardAE, 2'b00);
    clearIns(); MemReadE = 1; WriteRegE = 8; RtD = 8; #1;
    check("loaduse", {StallF, StallD, StallE, FlushE}, 4'b1101);
    WriteRegE = 0; #1;
    check("loaduse_r0", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}, 8'h00);
    clearIns(); BranchD = 2'b01; RegWriteE = 1; WriteRegE = 3; RsD = 3; #1;
    check("brhaz_E", {StallF, StallD, FlushE}, 3'b111);
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 3; #1;
    check("brfwd_stall", {StallF, StallD, FlushE}, 3'b000);
    check("brfwd_AD", ForwardAD, 1'b1);
    clearIns();
    @(negedge clk); DivStartE = 1; #1;
    check("div_t_stall", {StallE, DivBusyE}, 2'b10);
    for (int k = 1; k <= DIV + 2; k++) begin
      @(negedge clk); DivStartE = 0; #1;
      if (k <= DIV) check("div_busy", {StallE, FlushM, DivBusyE, DivReadyE}, 4'b1110);
      else if (k == DIV + 1) check("div_done", {StallE, DivBusyE, DivReadyE}, 3'b001);
      else check("div_idle", {StallE, DivBusyE, DivReadyE}, 3'b000);
    end
    @(negedge clk); DivStartE = 1;
    @(negedge clk); DivStartE = 0; DmemStallM = 1; ExceptM = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mem_stall", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}, 8'hF1);
      check("mem_busy", DivBusyE, 1'b1);
      @(negedge clk);
    end
    DmemStallM = 0; #1;
    check("exc_act", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW}, 8'h0F);
    @(negedge clk); ExceptM = 0; #1;
    check("exc_idle", {DivBusyE, DivReadyE, StallE}, 3'b000);
    @(negedge clk); DivStartE = 1;
    @(negedge clk); DivStartE = 0;
    @(negedge clk); #1;
    check("pre_rst_busy", DivBusyE, 1'b1);
    rst = 1; #1;
    check("async_rst", {DivBusyE, StallE}, 2'b00);
    @(negedge clk); rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("post_rst", {StallF, StallE, DivBusyE, DivReadyE}, 4'b0000);
    end
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    cyc = 0; bStart = 1; bEnd = 0; done = 0;
    for (int i = 0; i < 500; i++) randomCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
